// File: rtl/elixirchip_es1_spu_op_reg_arb.sv
// Round-robin arbiter that shares one op-register write port among N requesters.
// A granted requester may set s_lock to keep exclusive ownership over
// consecutive transfers until it releases the lock.
//
// Handshake: requester i is requesting while s_valid[i] | s_clear[i]. s_ready[i]
// is the combinational one-hot grant. A transfer happens on a rising edge where
// cke=1 and s_ready[i]=1. Requesters keep s_valid/s_clear/s_data stable until
// granted. Withdrawing a request before its grant is allowed. The granted
// transfer appears on m_* one cycle later.
module elixirchip_es1_spu_op_reg_arb #(
  parameter int  N          = 4,
  parameter int  DATA_BITS  = 8,
  parameter type data_t     = logic [DATA_BITS-1:0],
  parameter data_t CLEAR_DATA = '0,
  parameter int  ID_BITS    = ($clog2(N) > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cke,
  input  data_t              s_data [N],
  input  logic [N-1:0]       s_clear,
  input  logic [N-1:0]       s_valid,
  input  logic [N-1:0]       s_lock,
  output logic [N-1:0]       s_ready,
  output data_t              m_data,
  output logic               m_clear,
  output logic               m_valid,
  output logic [ID_BITS-1:0] m_id,
  output logic               m_locked
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [ID_BITS-1:0]   r_ptr;
  logic [ID_BITS-1:0]   r_owner;
  logic [ID_BITS-1:0]   w_ptr_next;
  logic [ID_BITS-1:0]   w_owner_next;
  logic [N-1:0]         w_req;
  logic                 w_grant_valid;
  logic [ID_BITS-1:0]   w_grant_id;

  // Index after i, wrapping N-1 back to 0 (N need not be a power of two).
  function automatic logic [ID_BITS-1:0] next_idx(input logic [ID_BITS-1:0] i);
    if (int'(i) == N - 1) begin
      return '0;
    end
    return i + ID_BITS'(1);
  endfunction

  // Grant selection: owner only while locked, else first requester at or after ptr.
  always_comb begin
    int idx;
    w_req         = s_valid | s_clear;
    w_grant_valid = 1'b0;
    w_grant_id    = '0;
    idx           = 0;
    if (reset && cke) begin
      if (r_state == ST_LOCKED) begin
        if (w_req[r_owner]) begin
          w_grant_valid = 1'b1;
          w_grant_id    = r_owner;
        end
      end else begin
        // Walk from farthest to nearest so the nearest requester wins.
        for (int k = N - 1; k >= 0; k--) begin
          idx = (int'(r_ptr) + k) % N;
          if (w_req[idx[ID_BITS-1:0]]) begin
            w_grant_valid = 1'b1;
            w_grant_id    = idx[ID_BITS-1:0];
          end
        end
      end
    end
  end

  // One-hot ready decoded from the grant.
  always_comb begin
    s_ready = '0;
    if (w_grant_valid) begin
      s_ready[w_grant_id] = 1'b1;
    end
  end

  // FSM next state, owner and round-robin pointer.
  always_comb begin
    w_state_next = r_state;
    w_owner_next = r_owner;
    w_ptr_next   = r_ptr;
    if (w_grant_valid) begin
      case (r_state)
        ST_IDLE: begin
          w_ptr_next = next_idx(w_grant_id);
          if (s_lock[w_grant_id]) begin
            w_state_next = ST_LOCKED;
            w_owner_next = w_grant_id;
          end
        end
        ST_LOCKED: begin
          // Releasing transfer is still issued; fairness resumes after the owner.
          if (!s_lock[w_grant_id]) begin
            w_state_next = ST_IDLE;
            w_ptr_next   = next_idx(r_owner);
          end
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State registers and the registered downstream drive.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      m_data  <= CLEAR_DATA;
      m_clear <= 1'b0;
      m_valid <= 1'b0;
      m_id    <= '0;
    end else if (cke) begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_owner <= w_owner_next;
      if (w_grant_valid) begin
        m_data  <= s_data[w_grant_id];
        m_clear <= s_clear[w_grant_id];
        m_valid <= s_valid[w_grant_id];
        m_id    <= w_grant_id;
      end else begin
        m_clear <= 1'b0;
        m_valid <= 1'b0;
      end
    end
  end

  // m_locked is a direct view of the state register.
  assign m_locked = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_elixirchip_es1_spu_op_reg_arb.sv
// Bench for the op-register arbiter: directed scenarios followed by random
// traffic, all checked against a behavioural grant/lock model.
module tb_elixirchip_es1_spu_op_reg_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int W  = DW + 1 + 1 + IW + 1;

  logic          clk;
  logic          reset;
  logic          cke;
  logic [DW-1:0] s_data [N];
  logic [N-1:0]  s_clear;
  logic [N-1:0]  s_valid;
  logic [N-1:0]  s_lock;
  logic [N-1:0]  s_ready;
  logic [DW-1:0] m_data;
  logic          m_clear;
  logic          m_valid;
  logic [IW-1:0] m_id;
  logic          m_locked;

  int total = 0;
  int bad   = 0;

  // Scoreboard queue of expected {m_data, m_clear, m_valid, m_id, m_locked}.
  logic [W-1:0] exp_q[$];

  // Reference model state.
  int            mdl_ptr   = 0;
  int            mdl_owner = 0;
  bit            mdl_lock  = 0;
  logic [DW-1:0] e_data    = '0;
  logic          e_clear   = 1'b0;
  logic          e_valid   = 1'b0;
  logic [IW-1:0] e_id      = '0;

  elixirchip_es1_spu_op_reg_arb #(
    .N         (N),
    .DATA_BITS (DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cke      (cke),
    .s_data   (s_data),
    .s_clear  (s_clear),
    .s_valid  (s_valid),
    .s_lock   (s_lock),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_clear  (m_clear),
    .m_valid  (m_valid),
    .m_id     (m_id),
    .m_locked (m_locked)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner under the arbitration rules, or -1 when nobody is granted.
  function automatic int model_grant();
    if (!reset || !cke) return -1;
    if (mdl_lock) return (s_valid[mdl_owner] | s_clear[mdl_owner]) ? mdl_owner : -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mdl_ptr + k) % N;
      if (s_valid[c] | s_clear[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_all();
    s_valid = '0;
    s_clear = '0;
    s_lock  = '0;
  endtask

  // One clock: check grant, advance model, check registered outputs.
  task automatic tick();
    int           g;
    logic [N-1:0] exp_ready;
    logic [W-1:0] e;
    #1;
    g = model_grant();
    exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0;
    total++;
    assert (s_ready === exp_ready) else begin
      bad++;
      $error("FAIL s_ready got=%b exp=%b", s_ready, exp_ready);
    end
    if (!reset) begin
      mdl_ptr = 0; mdl_lock = 0; mdl_owner = 0;
      e_data = '0; e_clear = 1'b0; e_valid = 1'b0; e_id = '0;
    end else if (cke) begin
      if (g >= 0) begin
        e_data  = s_data[g];
        e_clear = s_clear[g];
        e_valid = s_valid[g];
        e_id    = IW'(g);
        if (!mdl_lock) begin
          mdl_ptr = (g + 1) % N;
          if (s_lock[g]) begin
            mdl_lock  = 1;
            mdl_owner = g;
          end
        end else if (!s_lock[g]) begin
          mdl_lock = 0;
          mdl_ptr  = (g + 1) % N;
        end
      end else begin
        e_valid = 1'b0;
        e_clear = 1'b0;
      end
    end
    exp_q.push_back({e_data, e_clear, e_valid, e_id, mdl_lock});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++;
    assert ({m_data, m_clear, m_valid, m_id, m_locked} === e) else begin
      bad++;
      $error("FAIL m_out got=%h/%b/%b/%0d/%b exp=%h/%b/%b/%0d/%b",
             m_data, m_clear, m_valid, m_id, m_locked,
             e[W-1 -: DW], e[4], e[3], e[2:1], e[0]);
    end
    @(negedge clk);
  endtask

  // Stimulus
  initial begin
    reset = 1'b0;
    cke   = 1'b1;
    clear_all();
    for (int i = 0; i < N; i++) s_data[i] = '0;
    @(negedge clk);

    // Reset with requests present; no grant and cke ignored.
    s_valid = 4'hF;
    tick();
    cke = 1'b0;
    tick();
    cke = 1'b1;
    reset = 1'b1;
    clear_all();
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_id", 32'(m_id), 0);
    chk("rst_locked", 32'(m_locked), 0);

    // All four requesting continuously: plain rotation.
    for (int i = 0; i < N; i++) s_data[i] = 8'(i * 8'h11);
    s_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("rr_id", 32'(m_id), k % N);
      chk("rr_data", 32'(m_data), (k % N) * 8'h11);
      chk("rr_valid", 32'(m_valid), 1);
    end

    // Clear and write together from requester 2 alone.
    clear_all();
    s_valid[2] = 1'b1;
    s_clear[2] = 1'b1;
    s_data[2]  = 8'h5A;
    tick();
    chk("clr_clear", 32'(m_clear), 1);
    chk("clr_valid", 32'(m_valid), 1);
    chk("clr_id", 32'(m_id), 2);
    chk("clr_data", 32'(m_data), 8'h5A);
    clear_all();
    s_valid = 4'hF;
    #1;
    chk("clr_ptr3", 32'(s_ready), 4'b1000);
    tick();

    // Requester 1 holds the lock for three transfers, then releases.
    clear_all();
    s_valid[0] = 1'b1;
    tick();
    s_valid   = 4'hF;
    s_lock[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      s_data[1] = 8'($urandom);
      tick();
      chk("lock_id", 32'(m_id), 1);
      chk("lock_flag", 32'(m_locked), 1);
    end
    s_lock[1] = 1'b0;
    tick();
    chk("unlock_id", 32'(m_id), 1);
    chk("unlock_flag", 32'(m_locked), 0);
    s_valid[1] = 1'b0;
    tick();
    chk("after_unlock_id", 32'(m_id), 2);

    // Clock-enable gap between grants to 0 and 3.
    reset = 1'b0;
    clear_all();
    tick();
    reset = 1'b1;
    s_valid = 4'b1001;
    tick();
    chk("cke_first", 32'(m_id), 0);
    s_valid[0] = 1'b0;
    cke = 1'b0;
    tick();
    chk("cke_hold_id", 32'(m_id), 0);
    chk("cke_hold_valid", 32'(m_valid), 1);
    cke = 1'b1;
    tick();
    chk("cke_second", 32'(m_id), 3);

    // Reset while requester 3 owns the lock.
    clear_all();
    s_valid[3] = 1'b1;
    s_lock[3]  = 1'b1;
    s_data[3]  = 8'hC3;
    tick();
    tick();
    chk("own3_locked", 32'(m_locked), 1);
    reset = 1'b0;
    tick();
    chk("rstlk_valid", 32'(m_valid), 0);
    chk("rstlk_data", 32'(m_data), 0);
    chk("rstlk_locked", 32'(m_locked), 0);
    reset = 1'b1;
    s_lock  = '0;
    s_valid = 4'b1001;
    tick();
    chk("rstlk_first", 32'(m_id), 0);

    // Idle after a write: data and id hold, valid drops.
    clear_all();
    s_valid[1] = 1'b1;
    s_data[1]  = 8'hA5;
    tick();
    clear_all();
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("idle_valid", 32'(m_valid), 0);
      chk("idle_data", 32'(m_data), 8'hA5);
      chk("idle_id", 32'(m_id), 1);
    end

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      reset   = ($urandom_range(0, 49) != 0);
      cke     = ($urandom_range(0, 7) != 0);
      s_valid = 4'($urandom);
      s_clear = 4'($urandom & $urandom);
      s_lock  = 4'($urandom);
      for (int i = 0; i < N; i++) s_data[i] = 8'($urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/elixirchip_es1_spu_op_reg_arb.md
ELIXIRCHIP_ES1_SPU_OP_REG_ARB -- requirements
Module: elixirchip_es1_spu_op_reg_arb

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters sharing one op-register write port (2..16).
REQ-002 SHALL have parameter DATA_BITS, default 8: write data width.
REQ-003 SHALL have parameter data_t, default logic [DATA_BITS-1:0]: data type.
REQ-004 SHALL have parameter CLEAR_DATA, default '0: m_data value after reset.
REQ-005 SHALL have parameter ID_BITS, default max(1, $clog2(N)): grant index width.
REQ-006 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-007 SHALL have port reset  in  1  one clock; reset is synchronous and active-low (logic reset when reset==0 at a rising clk edge).
REQ-008 SHALL have port cke  in  1  clock enable.
REQ-009 SHALL have port s_data  in  N x data_t  per-requester write data.
REQ-010 SHALL have port s_clear  in  N  per-requester clear request.
REQ-011 SHALL have port s_valid  in  N  per-requester write request.
REQ-012 SHALL have port s_lock  in  N  per-requester keep-ownership flag, sampled with the granted request.
REQ-013 SHALL have port s_ready  out  N  one-hot grant, combinational.
REQ-014 SHALL have ports m_data  out  data_t, m_clear  out  1, m_valid  out  1: registered drive of the downstream op register.
REQ-015 SHALL have port m_id  out  ID_BITS  index of requester whose transfer is on m_*.
REQ-016 SHALL have port m_locked  out  1  high while in LOCKED state.

Function
REQ-017 SHALL treat requester i as requesting when s_valid[i] | s_clear[i].
REQ-018 SHALL, when cke=1, assert s_ready[g] for exactly one requesting g chosen round-robin: first requesting index at or after ptr, wrapping N-1 -> 0; s_ready all 0 if none request or cke=0.
REQ-019 SHALL, on a rising edge with cke=1 and grant g, register m_data<=s_data[g], m_clear<=s_clear[g], m_valid<=s_valid[g], m_id<=g (latency 1 from grant).
REQ-020 SHALL pass s_clear and s_valid both when simultaneously asserted by g; downstream clear has precedence.
REQ-021 SHALL, on a cke=1 edge with no grant, set m_valid<=0, m_clear<=0 and hold m_data and m_id unchanged.
REQ-022 SHALL, on a cke=0 edge, hold all registers and state (m_* stable).
REQ-023 SHALL update ptr<=(g+1) mod N after each grant in IDLE; ptr unchanged otherwise.
REQ-024 SHALL implement states IDLE and LOCKED with owner register.
REQ-025 SHALL transition IDLE->LOCKED, owner<=g, when grant g has s_lock[g]=1.
REQ-026 SHALL in LOCKED consider only owner eligible; other requests get no s_ready regardless of ptr.
REQ-027 SHALL transition LOCKED->IDLE when owner is granted with s_lock[owner]=0 (that transfer still issued), setting ptr<=(owner+1) mod N.
REQ-028 SHALL remain LOCKED indefinitely while owner is idle; no timeout.
REQ-029 SHALL assert m_locked exactly while state==LOCKED (registered).
REQ-030 SHALL require requesters to hold s_valid/s_clear/s_data stable until s_ready; dropping a request before grant is legal and loses nothing.

Reset
REQ-031 SHALL, when reset==0 at a rising edge, regardless of cke, set m_valid=0, m_clear=0, m_data=CLEAR_DATA, m_id=0, m_locked=0, ptr=0, state=IDLE.
REQ-032 SHALL hold s_ready all 0 while reset==0.
REQ-033 SHALL discard any in-flight lock when reset asserts mid-burst; first grant after release starts from requester 0.

Verification
REQ-034 SHALL pass: N=4, all four s_valid=1 constant, data=i*0x11 -> m_id sequence 0,1,2,3,0..., m_data 0x00,0x11,0x22,0x33, m_valid=1 every cycle.
REQ-035 SHALL pass: requester 2 s_clear=1 and s_valid=1, data 0x5A, alone -> next cycle m_clear=1, m_valid=1, m_id=2, ptr=3.
REQ-036 SHALL pass: requester 1 asserts s_lock for 3 transfers while 0,2,3 request -> m_id 1,1,1, then 1 (s_lock=0), then 2; m_locked high for cycles between.
REQ-037 SHALL pass: cke toggling 1,0,1 with requests 0 and 3 -> s_ready 0 during cke=0, m_* stable, order 0 then 3 unchanged.
REQ-038 SHALL pass: reset=0 during LOCKED owner 3 -> m_valid=0, m_data=CLEAR_DATA, m_locked=0; after release with requests 0 and 3, first grant 0.
REQ-039 SHALL pass: no requests for 5 cke cycles after write 0xA5 -> m_valid=0, m_data stays 0xA5, m_id unchanged.
